// File: rtl/vga_fb_arbiter.sv
// Shares one single-port pixel RAM between scanout reads (strict priority) and a req/ack writer.
// Latency: px_valid 3 clks after px_req; wr_ack 1 clk after a write grant. Writer waits while scanout reads.
// Optional build macro WR_BLANK_ONLY_EN restricts writes to blanking (disp_active low).
module vga_fb_arbiter #(
    parameter int PIX_COUNT = 307200,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic              px_req,
    input  logic              frame_start,
    input  logic              disp_active,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ok;
    logic              grant_rd;
    logic              grant_wr;
    logic              rd_s1;
    logic              rd_s2;

`ifdef WR_BLANK_ONLY_EN
    assign wr_ok = ~disp_active;
`else
    logic unused_disp_active;
    assign unused_disp_active = disp_active;
    assign wr_ok = 1'b1;
`endif

    // wr_ack high marks the commit cycle; a still-high wr_req there is the old request.
    always_comb begin
        rd_addr  = frame_start ? '0 : rd_ptr;
        grant_rd = px_req;
        grant_wr = ~px_req & wr_req & ~wr_ack & wr_ok;
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            rd_ptr    <= '0;
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            px_valid  <= 1'b0;
            px_data   <= '0;
            wr_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rd_s1    <= grant_rd;
            rd_s2    <= rd_s1;
            px_valid <= rd_s2;
            if (rd_s2) begin
                px_data <= mem_rdata;
            end
            wr_ack <= grant_wr;
            mem_en <= grant_rd | grant_wr;
            mem_we <= grant_wr;
            if (grant_rd) begin
                mem_addr <= rd_addr;
                rd_ptr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            end else begin
                if (frame_start) begin
                    rd_ptr <= '0;
                end
                if (grant_wr) begin
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a small 16-pixel frame and a synchronous RAM model.
module tb_vga_fb_arbiter;

    localparam int PIX = 16;
    localparam int AW  = 4;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          px_req = 1'b0;
    logic          frame_start = 1'b0;
    logic          disp_active = 1'b0;
    logic [DW-1:0] px_data;
    logic          px_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [PIX];
    int cyc = 0;
    int n_wr = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {int c; logic [DW-1:0] d;} rd_e_t;
    typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} wr_e_t;
    rd_e_t rd_q[$];
    wr_e_t wr_q[$];

    vga_fb_arbiter #(.PIX_COUNT(PIX), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK50MHZ(clk), .RST(rst), .px_req(px_req), .frame_start(frame_start),
        .disp_active(disp_active), .px_data(px_data), .px_valid(px_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                n_wr <= n_wr + 1;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents px_valid or wr_ack.
    rd_e_t re;
    wr_e_t we;
    always @(negedge clk) begin
        if (!rst && px_valid) begin
            if (rd_q.size() == 0) begin
                chk("spurious_px_valid", 32'(cyc), 32'hffff_ffff);
            end else begin
                re = rd_q.pop_front();
                chk("px_valid_cycle", 32'(cyc), 32'(re.c));
                chk("px_data", 32'(px_data), 32'(re.d));
            end
        end
        if (!rst && wr_ack) begin
            if (wr_q.size() == 0) begin
                chk("spurious_wr_ack", 32'(cyc), 32'hffff_ffff);
            end else begin
                we = wr_q.pop_front();
                chk("wr_ack_cycle", 32'(cyc), 32'(we.c));
                chk("wr_mem_port", {19'd0, mem_en, mem_we, mem_addr, mem_wdata},
                    {19'd0, 1'b1, 1'b1, we.a, we.d});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One scanout request this cycle; pixel expected 3 clocks later.
    task automatic rd(input bit fs, input logic [DW-1:0] exp);
        px_req = 1'b1;
        frame_start = fs;
        rd_q.push_back('{cyc + 3, exp});
        tick();
        px_req = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {8'd0, px_valid, wr_ack, mem_en, mem_we, px_data, mem_addr, mem_wdata}, 32'd0);
    endtask

    initial begin
        int w0;
        int c0;
        for (int i = 0; i < PIX; i++) ram[i] = DW'(i);

        // Power-on reset
        rst = 1'b1;
        idle(2);
        chk_zero("reset_outputs");
        rst = 1'b0;
        idle(2);

        // Reset mid-read drops the read; first read after release is addr 0
        px_req = 1'b1;
        tick();
        px_req = 1'b0;
        rst = 1'b1;
        idle(2);
        chk_zero("reset_midread_outputs");
        rst = 1'b0;
        idle(1);
        rd(1'b0, 8'd0);
        idle(5);

        // Scanout every second clock
        for (int i = 0; i < 5; i++) begin
            rd(i == 0, DW'(i));
            tick();
        end
        idle(4);

        // Back-to-back wrap across the 16-pixel frame
        for (int i = 0; i < 18; i++) rd(i == 0, DW'(i % PIX));
        // frame_start with the 5th request
        for (int i = 0; i < 6; i++) rd(i == 0 || i == 4, DW'(i < 4 ? i : i - 4));
        // frame_start alone rewinds the pointer (it was at 2)
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        rd(1'b0, 8'd0);
        idle(5);

        // Collision: read wins, write lands in the next free clock
        w0 = n_wr;
        wr_req = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'hA5;
        wr_q.push_back('{cyc + 2, 4'd5, 8'hA5});
        rd(1'b1, 8'd0);
        for (int i = 0; i < 4 && !wr_ack; i++) tick();
        wr_req = 1'b0;
        idle(4);
        chk("collision_write_count", 32'(n_wr - w0), 32'd1);
        chk("collision_ram5", 32'(ram[5]), 32'h0000_00A5);

        // Held request: one grant per two clocks
        w0 = n_wr;
        c0 = cyc;
        wr_req = 1'b1;
        wr_addr = 4'd8;
        wr_data = 8'h3C;
        wr_q.push_back('{c0 + 1, 4'd8, 8'h3C});
        wr_q.push_back('{c0 + 3, 4'd8, 8'h3C});
        wr_q.push_back('{c0 + 5, 4'd8, 8'h3C});
        idle(6);
        wr_req = 1'b0;
        idle(3);
        chk("held_write_count", 32'(n_wr - w0), 32'd3);
        chk("held_ram8", 32'(ram[8]), 32'h0000_003C);

        // Write during the visible area
        c0 = cyc;
        wr_req = 1'b1;
        wr_addr = 4'd9;
        wr_data = 8'h5A;
`ifdef WR_BLANK_ONLY_EN
        wr_q.push_back('{c0 + 4, 4'd9, 8'h5A});
`else
        wr_q.push_back('{c0 + 1, 4'd9, 8'h5A});
`endif
        for (int i = 0; i < 8; i++) begin
            disp_active = (i < 3);
            tick();
            if (wr_ack) break;
        end
        wr_req = 1'b0;
        disp_active = 1'b0;
        idle(4);
        chk("visible_ram9", 32'(ram[9]), 32'h0000_005A);

        idle(4);
        chk("rd_scoreboard_empty", 32'(rd_q.size()), 32'd0);
        chk("wr_scoreboard_empty", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
